// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared state encoding, SDRAM command constants and default widths
package sdram_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_BA_W    = 2;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

endpackage

// File: rtl/sdram_cmd_mux.sv
// rtl/sdram_cmd_mux.sv - registered state-indexed mux onto the shared SDRAM cmd/addr/bank pins
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BA_W   = DEF_BA_W
) (
  input  logic              sclk,
  input  logic              reset,
  input  state_t            state,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_bank,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank
);

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_bank <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sdram_cmd  <= init_cmd;
          sdram_addr <= init_addr;
          sdram_bank <= '0;
        end
        ST_AREF: begin
          sdram_cmd  <= aref_cmd;
          sdram_addr <= aref_addr;
          sdram_bank <= '0;
        end
        ST_WRITE: begin
          sdram_cmd  <= wr_cmd;
          sdram_addr <= wr_addr;
          sdram_bank <= wr_bank;
        end
        ST_READ: begin
          sdram_cmd  <= rd_cmd;
          sdram_addr <= rd_addr;
          sdram_bank <= rd_bank;
        end
        default: begin
          // ARBIT (and any illegal code) parks the bus at NOP
          sdram_cmd  <= CMD_NOP;
          sdram_addr <= '0;
          sdram_bank <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - grant FSM with refresh priority, write/read alternation and grant watchdog
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BA_W    = DEF_BA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank,
  output logic              timeout_err
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic            last_wr;
  logic [WD_W-1:0] wd_cnt;
  logic            grant_end;
  logic            wd_expire;

  // Only the end pulse of the engine currently holding the bus counts
  always_comb begin
    grant_end = 1'b0;
    case (state)
      ST_AREF:  grant_end = aref_end;
      ST_WRITE: grant_end = wr_end;
      ST_READ:  grant_end = rd_end;
      default:  grant_end = 1'b0;
    endcase
  end

  // Counter value on the last permitted granted cycle
  assign wd_expire = (wd_cnt == WD_LAST);

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      last_wr     <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_done) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          wd_cnt <= '0;
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (wr_req && (!rd_req || !last_wr)) begin
            state   <= ST_WRITE;
            wr_en   <= 1'b1;
            last_wr <= 1'b1;
          end else if (rd_req) begin
            state   <= ST_READ;
            rd_en   <= 1'b1;
            last_wr <= 1'b0;
          end
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          if (grant_end || wd_expire) begin
            state   <= ST_ARBIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            if (!grant_end) timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_INIT;
          aref_en <= 1'b0;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

  sdram_cmd_mux #(
    .ADDR_W(ADDR_W),
    .BA_W  (BA_W)
  ) u_cmd_mux (
    .sclk      (sclk),
    .reset     (reset),
    .state     (state),
    .init_cmd  (init_cmd),
    .init_addr (init_addr),
    .aref_cmd  (aref_cmd),
    .aref_addr (aref_addr),
    .wr_cmd    (wr_cmd),
    .wr_addr   (wr_addr),
    .wr_bank   (wr_bank),
    .rd_cmd    (rd_cmd),
    .rd_addr   (rd_addr),
    .rd_bank   (rd_bank),
    .sdram_cmd (sdram_cmd),
    .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int ADDR_W = 12;
  localparam int BA_W   = 2;
  localparam int TO     = 15;

  logic              sclk = 1'b0;
  logic              reset;
  logic              init_done;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req, aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req, wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BA_W-1:0]   wr_bank;
  logic              rd_req, rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BA_W-1:0]   rd_bank;
  logic              aref_en, wr_en, rd_en;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_bank;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  logic [2:0] grant_q[$];
  logic [2:0] prev_en = 3'b000;

  always #5 sclk = ~sclk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .TIMEOUT(TO)) dut (
    .sclk(sclk), .reset(reset), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       aref;
    logic       wr;
    logic       rd;
    logic [2:0] grant;  // expected {aref_en, wr_en, rd_en}
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sclk);
  endtask

  function automatic logic [31:0] pins();
    return 32'({sdram_cmd, sdram_addr, sdram_bank});
  endfunction

  function automatic logic [31:0] en3();
    return 32'({aref_en, wr_en, rd_en});
  endfunction

  // Grant scoreboard: each rising en must match the next expected grant
  always @(negedge sclk) begin
    if (!reset && (({aref_en, wr_en, rd_en} & ~prev_en) != 3'b000)) begin
      if (grant_q.size() == 0) check("grant_unexpected", 32'({aref_en, wr_en, rd_en}), 32'(0));
      else check("grant_seq", 32'({aref_en, wr_en, rd_en}), 32'(grant_q.pop_front()));
    end
    prev_en <= {aref_en, wr_en, rd_en};
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic wait_any_en(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (aref_en || wr_en || rd_en) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    logic [31:0] exp_pins;
    logic [2:0]  g;
    int          n;
    int          cnt;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'b001};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'b010};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'b001};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b010};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 3'b100};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'b001};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b100};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'b010};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b100};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'b001};

    reset = 1'b1; init_done = 1'b0;
    init_cmd = CMD_PRE; init_addr = 12'h400;
    aref_req = 0; aref_end = 0; aref_cmd = CMD_AREF; aref_addr = '0;
    wr_req = 0; wr_end = 0; wr_cmd = CMD_WR; wr_addr = '0; wr_bank = '0;
    rd_req = 0; rd_end = 0; rd_cmd = CMD_RD; rd_addr = '0; rd_bank = '0;

    // Reset state
    step(); step();
    check("rst_en", en3(), 32'(0));
    check("rst_pins", pins(), 32'({CMD_NOP, 12'h000, 2'b00}));
    check("rst_state", 32'(dut.state), 32'(ST_INIT));
    check("rst_terr", 32'(timeout_err), 32'(0));
    reset = 1'b0;

    // INIT passes the init bus with bank 0
    step();
    check("init_pins", pins(), 32'({CMD_PRE, 12'h400, 2'b00}));
    repeat (7) step();
    init_done = 1'b1;
    step();
    check("arbit_state", 32'(dut.state), 32'(ST_ARBIT));
    check("arbit_en", en3(), 32'(0));
    step();
    check("arbit_pins_nop", pins(), 32'({CMD_NOP, 12'h000, 2'b00}));

    // Refresh beats a simultaneous write; one NOP cycle then write
    aref_req = 1; wr_req = 1;
    grant_q.push_back(3'b100); grant_q.push_back(3'b010);
    step();
    check("aref_first", en3(), 32'(3'b100));
    aref_req = 0; aref_end = 1;
    step();
    aref_end = 0;
    check("aref_gap", en3(), 32'(0));
    step();
    check("wr_after_aref", en3(), 32'(3'b010));
    wr_req = 0; wr_addr = 12'h155; wr_bank = 2'd2; wr_cmd = 4'b0100;
    step();
    check("wr_pins", pins(), 32'({4'b0100, 12'h155, 2'd2}));
    wr_end = 1;
    step();
    wr_end = 0;
    check("wr_released", en3(), 32'(0));
    step();

    // Arbitration table; last_wr is 1 on entry
    for (int i = 0; i < 11; i++) begin
      aref_req = vecs[i].aref; wr_req = vecs[i].wr; rd_req = vecs[i].rd;
      if (vecs[i].grant != 3'b000) grant_q.push_back(vecs[i].grant);
      step();
      check($sformatf("vec%0d_en", i), en3(), 32'(vecs[i].grant));
      aref_req = 0; wr_req = 0; rd_req = 0;
      if (vecs[i].grant != 3'b000) begin
        aref_cmd = CMD_AREF; aref_addr = ADDR_W'($urandom);
        wr_cmd = CMD_WR; wr_addr = ADDR_W'($urandom); wr_bank = BA_W'($urandom);
        rd_cmd = CMD_RD; rd_addr = ADDR_W'($urandom); rd_bank = BA_W'($urandom);
        case (vecs[i].grant)
          3'b100:  exp_pins = 32'({aref_cmd, aref_addr, 2'b00});
          3'b010:  exp_pins = 32'({wr_cmd, wr_addr, wr_bank});
          default: exp_pins = 32'({rd_cmd, rd_addr, rd_bank});
        endcase
        step();
        check($sformatf("vec%0d_pins", i), pins(), exp_pins);
        aref_end = vecs[i].grant[2]; wr_end = vecs[i].grant[1]; rd_end = vecs[i].grant[0];
        step();
        aref_end = 0; wr_end = 0; rd_end = 0;
        check($sformatf("vec%0d_drop", i), en3(), 32'(0));
      end
      step();
      check($sformatf("vec%0d_nop", i), pins(), 32'({CMD_NOP, 12'h000, 2'b00}));
    end

    // Both held high, 8-cycle bursts: W, R, W, R with one NOP between each
    wr_req = 1; rd_req = 1;
    for (int k = 0; k < 4; k++) grant_q.push_back((k % 2 == 0) ? 3'b010 : 3'b001);
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 3'b010 : 3'b001;
      wait_any_en(6, n);
      check($sformatf("alt%0d_latency", k), 32'(n), 32'(1));
      check($sformatf("alt%0d_en", k), en3(), 32'(g));
      repeat (7) step();
      wr_end = g[1]; rd_end = g[0];
      if (k == 3) begin wr_req = 0; rd_req = 0; end
      step();
      wr_end = 0; rd_end = 0;
      check($sformatf("alt%0d_gap", k), en3(), 32'(0));
    end
    step();

    // Read that never ends: watchdog releases after TO granted cycles
    check("pre_terr", 32'(timeout_err), 32'(0));
    rd_req = 1;
    grant_q.push_back(3'b001);
    step();
    check("to_granted", 32'(rd_en), 32'(1));
    rd_req = 0;
    cnt = 1;
    for (int k = 0; k < 40 && rd_en; k++) begin
      step();
      if (rd_en) cnt++;
    end
    check("to_cycles", 32'(cnt), 32'(TO));
    check("to_err_set", 32'(timeout_err), 32'(1));
    repeat (3) step();
    check("to_err_sticky", 32'(timeout_err), 32'(1));
    check("to_en_idle", en3(), 32'(0));

    // Asynchronous reset mid-write
    wr_req = 1;
    grant_q.push_back(3'b010);
    step();
    check("rw_granted", 32'(wr_en), 32'(1));
    wr_req = 0;
    step(); step();
    reset = 1'b1;
    #1;
    check("rw_en", en3(), 32'(0));
    check("rw_state", 32'(dut.state), 32'(ST_INIT));
    check("rw_cmd", 32'(sdram_cmd), 32'(CMD_NOP));
    check("rw_terr_clr", 32'(timeout_err), 32'(0));
    step();
    reset = 1'b0;
    step();
    check("rw_rearb", 32'(dut.state), 32'(ST_ARBIT));

    check("grant_queue_empty", 32'(grant_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
